pipelined_seg_adder: RTL
========================

Name: pipelined_seg_adder

Overview:
- Parametrised successor to the fixed-width ripple adders in the Vedic multiplier datapath.
- Splits a WIDTH-bit add into STAGES ripple segments, with one register stage per segment and the carry passed between stages.
- Gives a high-fmax adder for the wide partial-product summation of the larger multiplier generations.
- Uses a valid/ready handshake with backpressure so the adder can sit between pipelined partial-product generators and the result register.

Parameters:
- WIDTH, 12, operand and sum width in bits. Must be a multiple of STAGES.
- STAGES, 3, number of pipeline segments. Must be at least 1. Latency is STAGES cycles.
- SEG, WIDTH/STAGES, derived segment width (localparam).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- cin  in  1  carry-in into bit 0.
- out_valid  out  1  sum/cout valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result {a+b+cin}[WIDTH-1:0].
- cout  out  1  carry out of bit WIDTH-1.

Behaviour:
- Reset (async assert, sync release): all stage valid flags = 0, all data registers = 0. Outputs: out_valid=0, sum=0, cout=0. in_ready=1 immediately.
- Transfers: input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Stage k (0..STAGES-1) holds:
  - valid_k;
  - the carry out of segment k;
  - sum bits [SEG*(k+1)-1:0] computed so far;
  - the unconsumed operand segments above k, delayed unchanged.
- Stage 0 computes segment 0 from a, b and cin. Stage k computes segment k from the delayed operands and the carry registered in stage k-1. Each segment is a SEG-bit ripple add (half-adder/full-adder chain equivalent). No carry-lookahead between segments.
- Per-stage advance, with bubble collapsing:
  - last stage: adv_last = !valid_last || out_ready;
  - other stages: adv_k = !valid_k || adv_{k+1};
  - in_ready = adv_0 (combinational from out_ready and the valid flags; no combinational path from in_valid).
- When adv_k: stage k loads from stage k-1 (or from the inputs for k=0) and valid_k takes the upstream valid. Otherwise stage k holds all its contents.
- Latency: with no stalls, a result appears exactly STAGES cycles after input acceptance. Throughput is 1 per cycle.
- out_valid = valid_last, sum = full sum register, cout = carry of the last stage. These hold stable while out_valid && !out_ready.
- Ordering: results leave in acceptance order. No drop, no duplication.
- Full condition: all stages valid and out_ready=0 gives in_ready=0.
- Simultaneous events: input acceptance and output drain in the same cycle are both honoured.
- Wrap-around: the sum is modulo 2^WIDTH and cout carries the overflow bit. a=b=all-ones with cin=1 gives sum all-ones, cout=1.
- Reset mid-operation clears all in-flight results. Nothing emerges after reset release unless new inputs are accepted.
- STAGES=1: a single registered ripple adder with the same handshake.

Optional Feature:
- Macro: PIPELINED_SEG_ADDER_SUB_EN.
- With the macro defined:
  - extra port sub (in, 1), sampled with a and b on input acceptance;
  - when sub=1 the stage-0 operand B is ~b and the carry-in is forced to 1 (cin ignored), so sum = a-b mod 2^WIDTH and cout = 1 means no borrow (a>=b);
  - sub=0 behaves exactly like the base block.
- Without the macro: no sub port, addition only. Base-block behaviour is bit-identical to the build with the macro defined and sub tied to 0.

Test Plan (WIDTH=12, STAGES=3):
- Reset: hold rst=1, pulse clk -> out_valid=0, sum=0x000, cout=0, in_ready=1. Assert rst asynchronously mid-cycle -> out_valid falls without a clock edge.
- Carry ripple across all segments: a=0xFFF, b=0x001, cin=0, out_ready=1 -> 3 cycles later out_valid=1, sum=0x000, cout=1. Also a=0xFFF, b=0xFFF, cin=1 -> sum=0xFFF, cout=1.
- Back-to-back: accept (0x123,0x456,0) then (0x800,0x800,0) on consecutive cycles -> outputs on consecutive cycles: 0x579/cout 0, then 0x000/cout 1.
- Backpressure: out_ready=0, offer 4 operand pairs -> 3 accepted, then in_ready=0. The first result stays stable on sum. Raise out_ready -> all results drain in order, the 4th is accepted in the same cycle, and no bubbles appear.
- Reset mid-flight: accept 2 inputs, assert rst for 1 cycle before any result -> no out_valid ever appears for those inputs. The next accepted input returns the correct sum 3 cycles later.
- PIPELINED_SEG_ADDER_SUB_EN builds:
  - a=0x005, b=0x007, sub=1 -> sum=0xFFE, cout=0;
  - a=0x007, b=0x005, sub=1 -> sum=0x002, cout=1.

Source files
------------

// File: rtl/pipelined_seg_adder_if.sv
// Valid/ready operand and result bus for pipelined_seg_adder.
// PIPELINED_SEG_ADDER_SUB_EN adds the per-transaction sub select.
interface pipelined_seg_adder_if #(
  parameter int unsigned WIDTH = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef PIPELINED_SEG_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Upstream producer / downstream consumer side
  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef PIPELINED_SEG_ADDER_SUB_EN
    output sub,
`endif
    input  in_ready, out_valid, sum, cout
  );

  // Adder side
  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef PIPELINED_SEG_ADDER_SUB_EN
    input  sub,
`endif
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/pipelined_seg_adder.sv
// WIDTH-bit adder split into STAGES registered ripple segments with valid/ready flow control.
// WIDTH must be a multiple of STAGES. Define PIPELINED_SEG_ADDER_SUB_EN for a-b via the sub input.
module pipelined_seg_adder #(
  parameter int unsigned WIDTH  = 12,
  parameter int unsigned STAGES = 3
) (
  input logic                clk,
  input logic                rst,
  pipelined_seg_adder_if.slave bus
);
  localparam int unsigned SEG  = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] carry_q;
  logic [WIDTH-1:0]  sum_q [STAGES];
  // Remaining operand bits, shifted so the next segment always sits at [SEG-1:0]
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];

  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] up_valid;
  logic [STAGES-1:0] up_carry;
  logic [WIDTH-1:0]  up_a    [STAGES];
  logic [WIDTH-1:0]  up_b    [STAGES];
  logic [WIDTH-1:0]  up_sum  [STAGES];
  logic [SEG:0]      seg_res [STAGES];
  logic [WIDTH-1:0]  nxt_sum [STAGES];

  logic [WIDTH-1:0]  b_in;
  logic              c_in;

  // One SEG-bit ripple segment: full-adder chain, returns {carry, sum}
  function automatic logic [SEG:0] ripple_add(input logic [SEG-1:0] x,
                                               input logic [SEG-1:0] y,
                                               input logic           c);
    logic [SEG-1:0] s;
    logic           cy;
    s  = '0;
    cy = c;
    for (int unsigned i = 0; i < SEG; i++) begin
      s[i] = x[i] ^ y[i] ^ cy;
      cy   = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
    end
    return {cy, s};
  endfunction

`ifdef PIPELINED_SEG_ADDER_SUB_EN
  // Subtract as a + ~b + 1; the forced carry-in overrides cin
  assign b_in = bus.sub ? ~bus.b : bus.b;
  assign c_in = bus.sub | bus.cin;
`else
  assign b_in = bus.b;
  assign c_in = bus.cin;
`endif

  // Backward advance chain; a stage moves when empty or when its successor moves
  always_comb begin : advance
    logic go;
    adv       = '0;
    go        = !valid_q[LAST] || bus.out_ready;
    adv[LAST] = go;
    for (int k = int'(LAST) - 1; k >= 0; k--) begin
      go     = !valid_q[k] || go;
      adv[k] = go;
    end
  end

  // Upstream view of each stage: bus inputs for stage 0, previous stage registers otherwise
  always_comb begin : stage_inputs
    up_valid    = '0;
    up_carry    = '0;
    up_valid[0] = bus.in_valid;
    up_carry[0] = c_in;
    up_a[0]     = bus.a;
    up_b[0]     = b_in;
    up_sum[0]   = '0;
    for (int k = 1; k < int'(STAGES); k++) begin
      up_valid[k] = valid_q[k-1];
      up_carry[k] = carry_q[k-1];
      up_a[k]     = a_q[k-1];
      up_b[k]     = b_q[k-1];
      up_sum[k]   = sum_q[k-1];
    end
  end

  // Segment k adds its slice and merges it into the partial sum at bit SEG*k
  always_comb begin : segment_add
    for (int k = 0; k < int'(STAGES); k++) begin
      seg_res[k] = ripple_add(up_a[k][SEG-1:0], up_b[k][SEG-1:0], up_carry[k]);
      nxt_sum[k] = up_sum[k] | (WIDTH'(seg_res[k][SEG-1:0]) << (SEG * 32'(k)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin : stage_regs
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (adv[k]) begin
          valid_q[k] <= up_valid[k];
          carry_q[k] <= seg_res[k][SEG];
          sum_q[k]   <= nxt_sum[k];
          a_q[k]     <= up_a[k] >> SEG;
          b_q[k]     <= up_b[k] >> SEG;
        end
      end
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = valid_q[LAST];
  assign bus.sum       = sum_q[LAST];
  assign bus.cout      = carry_q[LAST];

endmodule
